seg7_history_scan: RTL and testbench
====================================

# seg7_history_scan

Display stage that consumes the 4-bit count produced by the free-running counter and drives a 4-digit multiplexed seven-segment display. It detects every change of the incoming value and keeps the last four distinct values in a history shift register. It scans these values onto the digits, newest on digit 0, and counts the changes it has seen. It sits directly downstream of the counter, on the same clock and reset.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit stays lit; legal range 1..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `din`  in  4  count value from counter `out`; need not be registered upstream.
- `hold`  in  1  when 1, freeze the history register; scanning and change counting continue.
- `seg`  out  7  segment drive, active-high; `seg[0]`=a … `seg[6]`=g.
- `an`  out  4  digit enable, one-hot, active-high; `an[0]` = newest value.
- `changes`  out  8  number of detected `din` changes, saturating at 255.

## Operation
- `din_q` (4b) holds the last accepted value. `chg = (din != din_q)` is combinational.
- On an edge with `chg`=1:
  - `din_q <= din`.
  - `changes` increments, unless it is already 255.
  - If `hold`=0, the history shifts: `hist[3]<=hist[2]`, `hist[2]<=hist[1]`, `hist[1]<=hist[0]`, `hist[0]<=din`.
- If `hold`=1, the history is unchanged. `din_q` and `changes` still update, so changes during hold are lost from the history.
- Scan prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps to 0.
  - When `pcnt==SCAN_DIV-1`, the digit index `idx` (2b) increments modulo 4 (3 → 0).
  - With SCAN_DIV=1, `idx` advances every cycle.
- Outputs are registered every cycle:
  - `an <= 1<<idx_next`.
  - `seg <= decode(hist_next[idx_next])`.
  - `an` and `seg` therefore always refer to the same digit.
- Decode table (hex digits, segments g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset (`rst`=1 at an edge) sets:
  - `din_q=0`, all `hist=0`, `pcnt=0`, `idx=0`, `changes=0`
  - `an=4'b0001`, `seg=7'h3F`
  - Reset overrides every other event in the same cycle.
- Reset mid-scan or mid-history discards all state. The first edge after reset with `din`≠0 counts as a change.

## Timing
- `din` changes before edge E0 → `hist[0]` and `changes` are updated at E0.
- `seg`/`an` show the new value at E0 when `idx_next`=0, i.e. zero extra latency, because outputs are computed from next-state values.
- Simultaneous change and scan wrap at one edge: the shift and the `idx` advance both occur. The output reflects the shifted history at the new index.
- A `din` pulse lasting exactly one cycle is detected twice, once on entry and once on exit.
- `changes` saturates: at 255, a further change leaves it at 255.
- `hold` is sampled at the same edge as `chg`; there is no pipelining of `hold`.

## Structure
- Shared package `seg7_pkg` contains:
  - `SEG_BLANK=7'h00`
  - the 16-entry segment constant set
  - `NUM_DIGITS=4`
- One natural sub-module: `seg7_decode`, purely combinational 4b → 7b, instantiated once on the next-state digit.
- Top-level contains:
  - change detector
  - history register
  - prescaler
  - index
  - saturating counter
  - output registers

## Test plan
- Reset with `din`=0, SCAN_DIV=4:
  - `an` = 0001, 0010, 0100, 1000, each for 4 cycles, repeating.
  - `seg`=3F throughout; `changes`=0.
- Counter drives 1,2,3,4 on successive edges:
  - `hist`={4,3,2,1} (digit 0 newest); `changes`=4.
  - With `an`=0001, `seg`=66; with `an`=1000, `seg`=06.
- `hold`=1, then `din` steps 5→6:
  - `changes` += 2.
  - History unchanged, digit 0 still shows 4 (66).
  - After `hold`=0 and `din`=7: `hist[0]`=7 (07), `hist[1]`=4.
- Counter free-runs 0..F for 300 changes → `changes` sticks at 255.
- Assert `rst` mid-scan while `idx`=2 → next edge `an`=0001, `seg`=3F, `changes`=0.
- SCAN_DIV=1: `an` rotates every cycle. A `din` change coinciding with the 3→0 wrap shows the new value on digit 0 at that same edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path.
// Segment bit 0 is segment a and bit 6 is segment g; all segments are active-high.
package seg7_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;
endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment decoder.
// The output is active-high, with bit 0 driving segment a.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_val,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_val)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_history_scan.sv
// Tracks the last four distinct input values and scans them onto a 4-digit display.
// Digit 0 always shows the newest value; the module also keeps a saturating count of changes.
module seg7_history_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [7:0] changes
);
  localparam logic [15:0] PCNT_MAX = 16'(SCAN_DIV - 1);

  logic [3:0]                  r_din_q;
  logic [NUM_DIGITS-1:0][3:0]  r_hist;
  logic [15:0]                 r_pcnt;
  logic [1:0]                  r_idx;
  logic [7:0]                  r_changes;
  logic [6:0]                  r_seg;
  logic [3:0]                  r_an;

  logic                        w_chg;
  logic                        w_wrap;
  logic [NUM_DIGITS-1:0][3:0]  w_hist_next;
  logic [1:0]                  w_idx_next;
  logic [6:0]                  w_seg_next;

  assign w_chg  = (din != r_din_q);
  assign w_wrap = (r_pcnt == PCNT_MAX);

  // The display path uses next-state values, so a new value can appear in the same cycle it arrives.
  assign w_hist_next = (w_chg && !hold) ? {r_hist[NUM_DIGITS-2:0], din} : r_hist;
  assign w_idx_next  = w_wrap ? r_idx + 2'd1 : r_idx;

  seg7_decode u_dec (
    .i_val (w_hist_next[w_idx_next]),
    .o_seg (w_seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_din_q   <= 4'h0;
      r_hist    <= '0;
      r_pcnt    <= 16'd0;
      r_idx     <= 2'd0;
      r_changes <= 8'd0;
      r_an      <= 4'b0001;
      r_seg     <= SEG_0;
    end else begin
      if (w_chg) begin
        r_din_q <= din;
        if (r_changes != 8'hFF) r_changes <= r_changes + 8'd1;
      end
      r_hist <= w_hist_next;
      r_pcnt <= w_wrap ? 16'd0 : r_pcnt + 16'd1;
      r_idx  <= w_idx_next;
      r_an   <= 4'b0001 << w_idx_next;
      r_seg  <= w_seg_next;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign changes = r_changes;
endmodule

// File: tb/tb_seg7_history_scan.sv
// Directed bench for seg7_history_scan, using two instances: SCAN_DIV=4 and SCAN_DIV=1.
// A behavioural model derives the expected digit from the number of edges since reset, and the values are checked every cycle.
module tb_seg7_history_scan;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] din = 4'h0;
  logic       hold = 1'b0;
  logic [6:0] seg4, seg1;
  logic [3:0] an4, an1;
  logic [7:0] chg4, chg1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg7_history_scan #(.SCAN_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .din(din), .hold(hold),
    .seg(seg4), .an(an4), .changes(chg4)
  );
  seg7_history_scan #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .hold(hold),
    .seg(seg1), .an(an1), .changes(chg1)
  );

  function automatic logic [6:0] lut(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // Model state: the number of edges since reset, the accepted values, and the change count.
  bit         m_valid = 1'b0;
  int         m_n = 0;
  int         m_chg = 0;
  logic [3:0] m_last = 4'h0;
  logic [3:0] m_hist [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_n     <= 0;
      m_chg   <= 0;
      m_last  <= 4'h0;
      m_hist  <= '{4'h0, 4'h0, 4'h0, 4'h0};
    end else begin
      m_n <= m_n + 1;
      if (din != m_last) begin
        m_last <= din;
        m_chg  <= (m_chg >= 255) ? 255 : m_chg + 1;
        if (!hold) begin
          m_hist[0] <= din;
          m_hist[1] <= m_hist[0];
          m_hist[2] <= m_hist[1];
          m_hist[3] <= m_hist[2];
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      automatic int i4 = (m_n / 4) % 4;
      automatic int i1 = m_n % 4;
      chk("an4",  int'(an4),  1 << i4);
      chk("seg4", int'(seg4), int'(lut(m_hist[i4])));
      chk("chg4", int'(chg4), m_chg);
      chk("an1",  int'(an1),  1 << i1);
      chk("seg1", int'(seg1), int'(lut(m_hist[i1])));
      chk("chg1", int'(chg1), m_chg);
    end
  end

  // Wait, with a cycle limit, until digit enable v is active on the chosen instance; then check seg against the given value.
  task automatic wait_an(input bit use1, input logic [3:0] v, input logic [6:0] exp_seg,
                         input string nm);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if ((use1 ? an1 : an4) == v) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: an=%b never reached, expected %b", nm, use1 ? an1 : an4, v);
    end else begin
      chk(nm, int'(use1 ? seg1 : seg4), int'(exp_seg));
    end
  endtask

  initial begin
    // Reset with din=0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_an",  int'(an4),  4'b0001);
    chk("rst_seg", int'(seg4), 7'h3F);
    chk("rst_chg", int'(chg4), 0);
    repeat (20) @(negedge clk);
    chk("idle_seg", int'(seg4), 7'h3F);

    // The counter drives 1, 2, 3, 4 on successive edges.
    for (int v = 1; v <= 4; v++) begin
      din = 4'(v);
      @(negedge clk);
    end
    chk("m_hist0", int'(m_hist[0]), 4);
    chk("m_hist3", int'(m_hist[3]), 1);
    chk("chg_4",   int'(chg4), 4);
    wait_an(1'b0, 4'b0001, 7'h66, "d0_is_4");
    wait_an(1'b0, 4'b1000, 7'h06, "d3_is_1");

    // Changes made while hold=1 are counted but do not enter the history.
    hold = 1'b1; din = 4'h5;
    @(negedge clk); din = 4'h6;
    @(negedge clk); hold = 1'b0;
    @(negedge clk);
    chk("hold_chg", int'(chg4), 6);
    chk("hold_m0",  int'(m_hist[0]), 4);
    wait_an(1'b0, 4'b0001, 7'h66, "hold_d0");
    din = 4'h7;
    @(negedge clk);
    chk("m7_hist0", int'(m_hist[0]), 7);
    chk("m7_hist1", int'(m_hist[1]), 4);
    wait_an(1'b0, 4'b0001, 7'h07, "d0_is_7");
    wait_an(1'b0, 4'b0010, 7'h66, "d1_is_4");

    // The counter free-runs for 300 changes, so the change count saturates.
    for (int k = 0; k < 300; k++) begin
      din = din + 4'h1;
      @(negedge clk);
    end
    chk("sat_chg4", int'(chg4), 255);
    chk("sat_chg1", int'(chg1), 255);
    chk("sat_model", m_chg, 255);

    // Reset asserted mid-scan while digit 2 is lit.
    wait_an(1'b0, 4'b0100, lut(m_hist[2]), "pre_rst_d2");
    rst = 1'b1; din = 4'h0;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_an",  int'(an4),  4'b0001);
    chk("mid_rst_seg", int'(seg4), 7'h3F);
    chk("mid_rst_chg", int'(chg4), 0);

    // SCAN_DIV=1: a change that coincides with the 3->0 wrap appears on digit 0 at the same edge.
    wait_an(1'b1, 4'b1000, 7'h3F, "d1_pre_wrap");
    din = 4'h9;
    @(negedge clk);
    chk("wrap_an1",  int'(an1),  4'b0001);
    chk("wrap_seg1", int'(seg1), 7'h6F);
    chk("wrap_chg1", int'(chg1), 1);
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
